// File: rtl/md5_block_engine.sv
// Iterative MD5 compression: one 512-bit block through 64 steps on a single step datapath.
// A start/busy/done handshake sequences capture, 64 step cycles, and the chaining-value add.
module md5_block_engine (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [511:0] msg_block,
    input  logic [127:0] chain_in,
    output logic         busy,
    output logic         done,
    output logic [127:0] digest_out
);

    typedef enum logic [1:0] {IDLE, RUN, ADD} state_t;

    localparam logic [31:0] T_ROM [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    // Indexed by {round, step mod 4}
    localparam logic [4:0] S_ROM [16] = '{
        5'd7, 5'd12, 5'd17, 5'd22,
        5'd5, 5'd9,  5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23,
        5'd6, 5'd10, 5'd15, 5'd21
    };

    state_t         state_q;
    logic [5:0]     step_q;
    logic [31:0]    a_q, b_q, c_q, d_q;
    logic [511:0]   msg_q;
    logic [127:0]   chain_q;
    logic           busy_q, done_q;
    logic [127:0]   digest_q;

    logic [31:0]    f, m_word, tmp, rot, b_d;
    logic [3:0]     g;
    logic [4:0]     sh;

    always_comb begin
        f = '0;
        g = '0;
        unique case (step_q[5:4])
            2'd0: begin f = (b_q & c_q) | (~b_q & d_q); g = step_q[3:0]; end
            2'd1: begin f = (b_q & d_q) | (c_q & ~d_q); g = step_q[3:0] * 4'd5 + 4'd1; end
            2'd2: begin f = b_q ^ c_q ^ d_q;            g = step_q[3:0] * 4'd3 + 4'd5; end
            default: begin f = c_q ^ (b_q | ~d_q);      g = step_q[3:0] * 4'd7; end
        endcase
        sh     = S_ROM[{step_q[5:4], step_q[1:0]}];
        m_word = msg_q[{g, 5'b0} +: 32];
        tmp    = a_q + f + m_word + T_ROM[step_q];
        rot    = (tmp << sh) | (tmp >> (6'd32 - {1'b0, sh}));
        b_d    = b_q + rot;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            step_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            msg_q    <= '0;
            chain_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            digest_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        msg_q   <= msg_block;
                        chain_q <= chain_in;
                        a_q     <= chain_in[31:0];
                        b_q     <= chain_in[63:32];
                        c_q     <= chain_in[95:64];
                        d_q     <= chain_in[127:96];
                        step_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q    <= d_q;
                    d_q    <= c_q;
                    c_q    <= b_q;
                    b_q    <= b_d;
                    step_q <= step_q + 6'd1;
                    if (step_q == 6'd63) state_q <= ADD;
                end
                ADD: begin
                    digest_q <= {d_q + chain_q[127:96], c_q + chain_q[95:64],
                                 b_q + chain_q[63:32],  a_q + chain_q[31:0]};
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign digest_out = digest_q;

endmodule

// File: tb/tb_md5_block_engine.sv
// Directed/randomized bench for md5_block_engine against an MD5 reference computed from RFC 1321 rules.
module tb_md5_block_engine;

    logic         clk, rst, start;
    logic [511:0] msg_block;
    logic [127:0] chain_in;
    logic         busy, done;
    logic [127:0] digest_out;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] kt [64];
    int sh_tab [4][4] = '{'{7, 12, 17, 22}, '{5, 9, 14, 20}, '{4, 11, 16, 23}, '{6, 10, 15, 21}};

    localparam logic [127:0] INIT_H  = {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};
    localparam logic [127:0] EMPTY_D = {32'h7e42f8ec, 32'h980980e9, 32'h04b2008f, 32'hd98c1dd4};
    localparam logic [127:0] ABC_D   = {32'h727fe128, 32'h7d3f96d6, 32'hb04fd23c, 32'h98500190};

    md5_block_engine dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .msg_block  (msg_block),
        .chain_in   (chain_in),
        .busy       (busy),
        .done       (done),
        .digest_out (digest_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [127:0] md5_ref(input logic [511:0] m, input logic [127:0] ch);
        logic [31:0] a, b, c, d, f, t, w;
        int unsigned g;
        int s;
        a = ch[31:0]; b = ch[63:32]; c = ch[95:64]; d = ch[127:96];
        for (int i = 0; i < 64; i++) begin
            case (i / 16)
                0: begin f = (b & c) | (~b & d); g = i; end
                1: begin f = (b & d) | (c & ~d); g = (5 * i + 1) % 16; end
                2: begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
                default: begin f = c ^ (b | ~d); g = (7 * i) % 16; end
            endcase
            s = sh_tab[i / 16][i % 4];
            w = m[32 * g +: 32];
            t = a + f + w + kt[i];
            a = d; d = c; c = b;
            b = b + ((t << s) | (t >> (32 - s)));
        end
        return {d + ch[127:96], c + ch[95:64], b + ch[63:32], a + ch[31:0]};
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32 * i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_block(input logic [511:0] m, input logic [127:0] ch, input bit scramble,
                             output logic [127:0] dig);
        int k;
        bit seen;
        @(negedge clk);
        msg_block = m; chain_in = ch; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        chk("accept_busy", {127'b0, busy}, 128'd1);
        seen = 1'b0;
        while (!seen && k < 200) begin
            if (scramble) begin msg_block = rand512(); chain_in = rand128(); end
            @(negedge clk);
            k++;
            if (done) seen = 1'b1;
        end
        chk("latency", 128'(k), 128'd65);
        chk("busy_at_done", {127'b0, busy}, 128'd0);
        dig = digest_out;
        @(negedge clk);
        chk("done_one_cycle", {127'b0, done}, 128'd0);
    endtask

    initial begin : stim
        logic [511:0] blk_empty, blk_abc, blk_a, blk_pad, rb;
        logic [127:0] dig, dig1, rc, exp_d;
        int k, busy_cnt, dones, done_k;
        int times [$];

        for (int i = 0; i < 64; i++) begin
            real x;
            x = $sin(real'(i + 1));
            if (x < 0.0) x = -x;
            kt[i] = 32'(longint'($floor(x * 4294967296.0)));
        end

        blk_empty = '0; blk_empty[31:0] = 32'h00000080;
        blk_abc = '0; blk_abc[31:0] = 32'h80636261; blk_abc[32 * 14 +: 32] = 32'h00000018;
        for (int i = 0; i < 16; i++) blk_a[32 * i +: 32] = 32'h61616161;
        blk_pad = '0; blk_pad[31:0] = 32'h00000080; blk_pad[32 * 14 +: 32] = 32'h00000200;

        rst = 1'b1; start = 1'b0; msg_block = '0; chain_in = '0;
        #12;
        chk("reset_busy", {127'b0, busy}, 128'd0);
        chk("reset_done", {127'b0, done}, 128'd0);
        chk("reset_digest", digest_out, 128'd0);
        @(negedge clk);
        rst = 1'b0;

        run_block(blk_empty, INIT_H, 1'b0, dig);
        chk("empty_digest", dig, EMPTY_D);

        run_block(blk_abc, INIT_H, 1'b1, dig);
        chk("abc_scrambled_digest", dig, ABC_D);
        repeat (5) @(negedge clk);
        chk("digest_hold", digest_out, ABC_D);

        // start pulses at E10 (RUN) and E65 (ADD) must be ignored
        @(negedge clk);
        msg_block = blk_empty; chain_in = INIT_H; start = 1'b1;
        @(negedge clk);
        start = 1'b0; k = 0; busy_cnt = int'(busy); dones = 0; done_k = -1;
        for (int j = 0; j < 140; j++) begin
            start = (k == 9 || k == 64);
            @(negedge clk);
            k++;
            busy_cnt += int'(busy);
            if (done) begin dones++; done_k = k; end
        end
        start = 1'b0;
        chk("busy_ignore_dones", 128'(dones), 128'd1);
        chk("busy_ignore_done_time", 128'(done_k), 128'd65);
        chk("busy_ignore_busy_cycles", 128'(busy_cnt), 128'd65);
        chk("busy_ignore_digest", digest_out, EMPTY_D);

        rb = rand512(); rc = rand128(); exp_d = md5_ref(rb, rc);
        @(negedge clk);
        msg_block = rb; chain_in = rc; start = 1'b1;
        k = -1;
        while (times.size() < 3 && k < 300) begin
            @(negedge clk);
            k++;
            if (done) begin
                times.push_back(k);
                chk("held_start_digest", digest_out, exp_d);
                chk("held_start_no_overlap", {127'b0, busy}, 128'd0);
            end
        end
        start = 1'b0;
        chk("held_start_count", 128'(times.size()), 128'd3);
        if (times.size() == 3) begin
            chk("held_start_first", 128'(times[0]), 128'd65);
            chk("held_start_gap1", 128'(times[1] - times[0]), 128'd66);
            chk("held_start_gap2", 128'(times[2] - times[1]), 128'd66);
        end
        repeat (70) @(negedge clk);

        @(negedge clk);
        msg_block = blk_abc; chain_in = INIT_H; start = 1'b1;
        @(negedge clk);
        start = 1'b0; k = 0;
        while (k < 30) begin @(negedge clk); k++; end
        #2 rst = 1'b1;
        #1;
        chk("midreset_busy", {127'b0, busy}, 128'd0);
        chk("midreset_done", {127'b0, done}, 128'd0);
        chk("midreset_digest", digest_out, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int j = 0; j < 80; j++) begin
            @(negedge clk);
            dones += int'(done);
        end
        chk("midreset_no_done", 128'(dones), 128'd0);
        run_block(blk_abc, INIT_H, 1'b0, dig);
        chk("post_reset_abc", dig, ABC_D);

        run_block(blk_a, INIT_H, 1'b0, dig1);
        chk("chain_block1", dig1, md5_ref(blk_a, INIT_H));
        run_block(blk_pad, dig1, 1'b0, dig);
        chk("chain_block2", dig, md5_ref(blk_pad, md5_ref(blk_a, INIT_H)));

        for (int n = 0; n < 4; n++) begin
            rb = rand512(); rc = rand128();
            run_block(rb, rc, 1'b1, dig);
            chk("random_block", dig, md5_ref(rb, rc));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
